// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus definitions: well-known register addresses and the
// sprite DMA controller state encoding.
package nes_bus_pkg;

    localparam logic [15:0] APU_OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] PPU_OAMDATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        DUMMY     = 3'd2,
        ALIGN     = 3'd3,
        READ      = 3'd4,
        WRITE     = 3'd5
    } dma_state_t;

    // The CPU keeps the bus in IDLE and while it is being parked in HALT_WAIT.
    function automatic logic dma_owns_bus(input dma_state_t s);
        return (s == DUMMY) || (s == ALIGN) || (s == READ) || (s == WRITE);
    endfunction

endpackage

// File: rtl/sprite_dma_bus_mux.sv
// Combinational CPU/DMA selector for the arbitrated system bus.
module sprite_dma_bus_mux (
    input  logic        dma_sel,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic [15:0] Addr_bus,
    output logic [7:0]  bus_wdata,
    output logic        bus_we
);

    always_comb begin
        Addr_bus  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_we    = cpu_we;
        if (dma_sel) begin
            Addr_bus  = dma_addr;
            bus_wdata = dma_wdata;
            bus_we    = dma_we;
        end
    end

endmodule

// File: rtl/sprite_dma_ctrl.sv
// Sprite (OAM) DMA controller and CPU/DMA bus arbiter for the NES core.
// Define SPRITE_DMA_ALIGN_EN to build the parity register and the ALIGN cycle.
module sprite_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR     = APU_OAMDMA_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = PPU_OAMDATA_ADDR
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_halt_ack,
    output logic        cpu_rdy,
    output logic [15:0] Addr_bus,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    input  logic [7:0]  Data_bus,
    output logic        dma_busy
);

    dma_state_t  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  xfer_byte_q, xfer_byte_d;
    logic        cpu_rdy_q, cpu_rdy_d;
    logic        dma_busy_q, dma_busy_d;

    logic        align_needed;
    logic        dma_sel;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_we;

`ifdef SPRITE_DMA_ALIGN_EN
    logic parity_q, parity_d;

    always_comb parity_d = ~parity_q;

    always_ff @(posedge clk_ph1) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end

    assign align_needed = parity_q;
`else
    assign align_needed = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        idx_d       = idx_q;
        xfer_byte_d = xfer_byte_q;
        dma_addr    = cpu_addr;
        dma_wdata   = xfer_byte_q;
        dma_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_we && (cpu_addr == TRIG_ADDR)) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    state_d = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (cpu_halt_ack) state_d = DUMMY;
            end
            DUMMY: begin
                state_d = align_needed ? ALIGN : READ;
            end
            ALIGN: begin
                state_d = READ;
            end
            READ: begin
                dma_addr    = {page_q, idx_q};
                xfer_byte_d = Data_bus;
                state_d     = WRITE;
            end
            WRITE: begin
                dma_addr = OAM_DATA_ADDR;
                dma_we   = 1'b1;
                idx_d    = idx_q + 8'd1;
                state_d  = (idx_q == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // RDY and busy are registered views of where the FSM is heading.
        cpu_rdy_d  = (state_d == IDLE);
        dma_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            state_q     <= IDLE;
            page_q      <= 8'h00;
            idx_q       <= 8'h00;
            xfer_byte_q <= 8'h00;
            cpu_rdy_q   <= 1'b1;
            dma_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            idx_q       <= idx_d;
            xfer_byte_q <= xfer_byte_d;
            cpu_rdy_q   <= cpu_rdy_d;
            dma_busy_q  <= dma_busy_d;
        end
    end

    // Reset hands the bus back to the CPU immediately, killing any pending OAM write.
    assign dma_sel  = dma_owns_bus(state_q) && !rst;
    assign cpu_rdy  = cpu_rdy_q;
    assign dma_busy = dma_busy_q;

    sprite_dma_bus_mux u_bus_mux (
        .dma_sel   (dma_sel),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .Addr_bus  (Addr_bus),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we)
    );

endmodule

// File: doc/sprite_dma_ctrl.md
# sprite_dma_ctrl

Sprite (OAM) DMA controller and system-bus arbiter for the NES core. A CPU write to the trigger register stalls the 6502 via its RDY input, takes ownership of the system address/data bus, and copies one 256-byte CPU page to the PPU OAM data port with alternating read/write cycles. When idle it passes the CPU bus through transparently.

## Interface
Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a DMA; the data byte is the source page.
- OAM_DATA_ADDR, 16'h2004, destination address written on every write cycle.

Ports:
- clk_ph1  in  1  system clock; one CPU cycle per rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address output.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe; high means the current cycle is a write.
- cpu_halt_ack  in  1  CPU is parked in a read cycle with RDY low.
- cpu_rdy  out  1  RDY to the CPU; low requests a stall.
- Addr_bus  out  16  arbitrated system address.
- bus_wdata  out  8  arbitrated write data.
- bus_we  out  1  arbitrated write strobe.
- Data_bus  in  8  system read data.
- dma_busy  out  1  high from the trigger cycle until the last write completes.

## Operation
- States: IDLE, HALT_WAIT, DUMMY, ALIGN, READ, WRITE.
- In IDLE and HALT_WAIT the CPU owns the bus:
  - Addr_bus = cpu_addr, bus_wdata = cpu_wdata, bus_we = cpu_we.
  - This mux is combinational.
- In DUMMY, ALIGN, READ and WRITE the DMA owns the bus.
- IDLE:
  - Transition: when cpu_we=1 and cpu_addr=TRIG_ADDR, latch page<=cpu_wdata and idx<=0, then go to HALT_WAIT.
  - Any other address, or a read of TRIG_ADDR, does not trigger.
- HALT_WAIT:
  - cpu_rdy=0.
  - Stay until cpu_halt_ack=1, then go to DUMMY.
- DUMMY:
  - Addr_bus=cpu_addr, bus_we=0; no write is issued.
  - Next state is ALIGN if parity=1, otherwise READ.
- ALIGN:
  - Same bus drive as DUMMY.
  - Next state is READ.
- READ:
  - Addr_bus={page,idx}, bus_we=0.
  - Latch Data_bus into xfer_byte at the cycle end.
  - Next state is WRITE.
- WRITE:
  - Addr_bus=OAM_DATA_ADDR, bus_wdata=xfer_byte, bus_we=1.
  - idx<=idx+1 (8-bit).
  - If idx was 8'hFF, go to IDLE; otherwise go to READ.
- Source addresses wrap within the page only; page 8'hFF reads 16'hFF00..16'hFFFF.
- Any page value, including 8'h20, is transferred with no special casing.
- A trigger is ignored while dma_busy=1.
- parity:
  - 1-bit free-running toggle on every clk_ph1 edge; cleared by rst.
  - It is sampled in DUMMY.

## Timing
- Reset values:
  - state=IDLE, cpu_rdy=1, dma_busy=0, parity=0, idx=0, page=0, xfer_byte=0.
  - Bus outputs follow the CPU inputs.
- cpu_rdy and dma_busy are registered:
  - Both change in the cycle after the trigger edge.
  - cpu_rdy returns to 1 in the cycle after the final WRITE.
- The first DMA-owned cycle is the one following the edge on which cpu_halt_ack=1 is sampled.
- DMA length from that edge:
  - 513 cycles when parity=0 in DUMMY (DUMMY + 512).
  - 514 cycles when parity=1 (DUMMY + ALIGN + 512).
- rst mid-transfer:
  - The next state is IDLE and cpu_rdy=1.
  - The bus returns to the CPU combinationally in that cycle.
  - No further OAM writes occur and the partial copy is not completed.
- A trigger write arriving in the same cycle as rst is discarded.

## Configuration
- SPRITE_DMA_ALIGN_EN defined:
  - The parity register and ALIGN state are built.
  - Length is 513 or 514 cycles, as above.
- SPRITE_DMA_ALIGN_EN undefined:
  - No parity register; ALIGN is unreachable and may be optimized out.
  - DUMMY always goes to READ, so every DMA is exactly 513 cycles.

## Structure
- Shared package nes_bus_pkg holds:
  - the dma_state_t enum (IDLE, HALT_WAIT, DUMMY, ALIGN, READ, WRITE);
  - the address constants APU_OAMDMA_ADDR=16'h4014 and PPU_OAMDATA_ADDR=16'h2004, which the parameters default from.
- One sub-module, sprite_dma_bus_mux:
  - Pure combinational CPU/DMA select for Addr_bus, bus_wdata and bus_we.
  - Select input is the DMA-owns-bus flag.
- The FSM, counters and latches stay in sprite_dma_ctrl.

## Test plan
- Even start: write 8'h02 to 16'h4014, cpu_halt_ack=1 next cycle, parity=0.
  - Reads 16'h0200..16'h02FF in order, each followed by a write to 16'h2004 carrying the byte just read.
  - cpu_rdy returns to 1 after exactly 513 DMA cycles.
- Odd start (SPRITE_DMA_ALIGN_EN defined): same stimulus with parity=1 at DUMMY.
  - One extra idle cycle with bus_we=0.
  - Total 514 cycles; the data sequence is identical.
- Delayed ack: hold cpu_halt_ack=0 for 3 cycles after the trigger.
  - cpu_rdy stays 0 and the bus stays CPU-owned for those cycles.
  - DUMMY starts the cycle after the ack.
- Wrap: page 8'hFF with Data_bus = low address byte.
  - Last read is at 16'hFFFF with value 8'hFF; no access to 16'h0000.
  - Busy drops after idx wraps.
- Reset mid-transfer: assert rst after the write of idx 8'h40.
  - Next cycle: cpu_rdy=1, dma_busy=0, Addr_bus=cpu_addr.
  - No further writes to 16'h2004.
- Non-trigger: a write to 16'h4015 and a read of 16'h4014 leave cpu_rdy=1 and dma_busy=0.
  - Without SPRITE_DMA_ALIGN_EN, the even and odd cases both measure 513 cycles.
